// File: rtl/miller_frame_tx_ctrl.sv
// Frame sequencer for a Miller encoder: preamble, sync, length, payload, guard.
// One bit per two clk2x cycles, MSB first, encoder phase cleared in ALIGN.
module miller_frame_tx_ctrl #(
    parameter int unsigned PREAMBLE_BITS = 16,
    parameter logic [31:0] PREAMBLE_PAT  = 32'hAAAAAAAA,
    parameter logic [7:0]  SYNC_WORD     = 8'hD3,
    parameter int unsigned GUARD_BITS    = 4
) (
    input  logic       clk2x,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output logic       enc_din,
    output logic       enc_enable,
    output logic       enc_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_PRE, S_SYNC, S_LEN, S_PAY, S_GUARD
    } state_t;

    localparam logic [4:0] PRE_LAST   = 5'(PREAMBLE_BITS - 1);
    localparam logic [4:0] GUARD_LAST = 5'(GUARD_BITS - 1);

    state_t     state_q, state_d;
    logic       ph_q, ph_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] len_q, len_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] acc_cnt_q, acc_cnt_d;
    logic [7:0] pay_cnt_q, pay_cnt_d;
    logic       abort_q, abort_d;
    logic       fin_q, fin_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       underrun_q, underrun_d;
    logic       byte_ready_q, byte_ready_d;
    logic       enc_din_q, enc_din_d;
    logic       enc_enable_q, enc_enable_d;
    logic       enc_rst_n_q, enc_rst_n_d;

    logic       xfer;
    logic       move;
    logic       need_byte;
    logic [4:0] field_last;
    logic [4:0] pre_idx;

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        acc_cnt_d   = acc_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        abort_d     = abort_q;
        fin_d       = 1'b0;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        move        = 1'b0;
        need_byte   = 1'b0;
        field_last  = 5'd7;
        pre_idx     = 5'd0;
        xfer        = byte_valid & byte_ready_q;

        case (state_q)
            S_PRE:   field_last = PRE_LAST;
            S_GUARD: field_last = GUARD_LAST;
            default: field_last = 5'd7;
        endcase

        case (state_q)
            S_IDLE: begin
                ph_d        = 1'b0;
                cnt_d       = 5'd0;
                abort_d     = 1'b0;
                hold_full_d = 1'b0;
                acc_cnt_d   = 8'd0;
                pay_cnt_d   = 8'd0;
                // The cycle right after a frame ends never starts a new one.
                if (start && !fin_q) begin
                    len_d   = len;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                ph_d    = 1'b0;
                cnt_d   = 5'd0;
                state_d = S_PRE;
            end
            default: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (cnt_q != field_last) begin
                        cnt_d = cnt_q + 5'd1;
                    end else begin
                        cnt_d = 5'd0;
                        case (state_q)
                            S_PRE:  state_d = S_SYNC;
                            S_SYNC: state_d = S_LEN;
                            S_LEN, S_PAY: begin
                                need_byte = (state_q == S_LEN) ? (len_q != 8'd0)
                                                               : (pay_cnt_q != len_q);
                                if (!need_byte) begin
                                    state_d = S_GUARD;
                                end else if (hold_full_q) begin
                                    move      = 1'b1;
                                    shift_d   = hold_q;
                                    pay_cnt_d = pay_cnt_q + 8'd1;
                                    state_d   = S_PAY;
                                end else begin
                                    underrun_d = 1'b1;
                                    abort_d    = 1'b1;
                                    state_d    = S_GUARD;
                                end
                            end
                            S_GUARD: begin
                                state_d = S_IDLE;
                                fin_d   = 1'b1;
                                done_d  = ~abort_q;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end
        endcase

        // A byte moved out and a byte arriving in the same cycle keeps the register full.
        if (move)
            hold_full_d = 1'b0;
        if (xfer) begin
            hold_d      = byte_data;
            hold_full_d = 1'b1;
            acc_cnt_d   = acc_cnt_q + 8'd1;
        end

        busy_d       = (state_d != S_IDLE);
        enc_enable_d = (state_d != S_IDLE) && (state_d != S_ALIGN);
        enc_rst_n_d  = (state_d != S_ALIGN);
        byte_ready_d = ((state_d == S_PRE) || (state_d == S_SYNC) ||
                        (state_d == S_LEN) || (state_d == S_PAY)) &&
                       !hold_full_d && (acc_cnt_d < len_d);

        pre_idx = PRE_LAST - cnt_d;
        case (state_d)
            S_PRE:   enc_din_d = PREAMBLE_PAT[pre_idx];
            S_SYNC:  enc_din_d = SYNC_WORD[3'd7 - cnt_d[2:0]];
            S_LEN:   enc_din_d = len_d[3'd7 - cnt_d[2:0]];
            S_PAY:   enc_din_d = shift_d[3'd7 - cnt_d[2:0]];
            default: enc_din_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk2x) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ph_q         <= 1'b0;
            cnt_q        <= 5'd0;
            len_q        <= 8'd0;
            hold_q       <= 8'd0;
            hold_full_q  <= 1'b0;
            shift_q      <= 8'd0;
            acc_cnt_q    <= 8'd0;
            pay_cnt_q    <= 8'd0;
            abort_q      <= 1'b0;
            fin_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            byte_ready_q <= 1'b0;
            enc_din_q    <= 1'b0;
            enc_enable_q <= 1'b0;
            enc_rst_n_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            acc_cnt_q    <= acc_cnt_d;
            pay_cnt_q    <= pay_cnt_d;
            abort_q      <= abort_d;
            fin_q        <= fin_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
            byte_ready_q <= byte_ready_d;
            enc_din_q    <= enc_din_d;
            enc_enable_q <= enc_enable_d;
            enc_rst_n_q  <= enc_rst_n_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign underrun   = underrun_q;
    assign enc_din    = enc_din_q;
    assign enc_enable = enc_enable_q;
    assign enc_rst_n  = enc_rst_n_q;

endmodule

// File: tb/tb_miller_frame_tx_ctrl.sv
// Directed bench for miller_frame_tx_ctrl: table of frames plus reset/back-to-back sequences.
module tb_miller_frame_tx_ctrl;

    logic       clk2x = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       busy;
    logic       done;
    logic       underrun;
    logic       enc_din;
    logic       enc_enable;
    logic       enc_rst_n;

    int checks = 0;
    int errors = 0;

    miller_frame_tx_ctrl dut (
        .clk2x      (clk2x),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .enc_din    (enc_din),
        .enc_enable (enc_enable),
        .enc_rst_n  (enc_rst_n)
    );

    always #5 clk2x = ~clk2x;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]      len;
        int              offer;   // bytes the source makes available, back to back
        logic [2:0][7:0] b;
        int              hs;      // expected handshakes
        int              und_k;   // enabled-cycle index of underrun pulse, -1 if none
        int              en;      // expected enabled cycles
        bit              done;
        bit              hold;    // keep start high for the whole frame
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Caller sets start=1 at a negedge; the following posedge is the accepting edge.
    task automatic run_frame(input vec_t v);
        logic       eb[$];
        logic [15:0] pre;
        logic [7:0]  syn;
        logic [7:0]  tmp;
        int          sent;
        int          idx;
        int          hs;
        bit          pend;
        pre  = 16'hAAAA;
        syn  = 8'hD3;
        sent = (v.offer < int'(v.len)) ? v.offer : int'(v.len);
        eb.delete();
        for (int i = 15; i >= 0; i--) eb.push_back(pre[i]);
        for (int i = 7; i >= 0; i--) eb.push_back(syn[i]);
        tmp = v.len;
        for (int i = 7; i >= 0; i--) eb.push_back(tmp[i]);
        for (int j = 0; j < sent; j++) begin
            tmp = v.b[j];
            for (int i = 7; i >= 0; i--) eb.push_back(tmp[i]);
        end
        for (int i = 0; i < 4; i++) eb.push_back(1'b0);
        chk("bit_count", eb.size() * 2, v.en);

        idx        = 0;
        hs         = 0;
        len        = v.len;
        byte_valid = (v.offer > 0);
        byte_data  = v.b[0];
        @(posedge clk2x);
        @(negedge clk2x);
        if (!v.hold) start = 1'b0;
        chk("align_busy", busy, 1);
        chk("align_enc_rst_n", enc_rst_n, 0);
        chk("align_enable", enc_enable, 0);
        chk("align_byte_ready", byte_ready, 0);
        pend = byte_valid & byte_ready;
        for (int k = 0; k < v.en; k++) begin
            @(negedge clk2x);
            if (pend) begin
                hs++;
                idx++;
                byte_valid = (idx < v.offer);
                if (idx < 3) byte_data = v.b[idx];
            end
            chk("enable", enc_enable, 1);
            chk("din", enc_din, eb[k/2]);
            chk("enc_rst_n", enc_rst_n, 1);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("underrun", underrun, (k == v.und_k) ? 1 : 0);
            pend = byte_valid & byte_ready;
        end
        @(negedge clk2x);
        if (pend) hs++;
        byte_valid = 1'b0;
        chk("end_done", done, v.done);
        chk("end_busy", busy, 0);
        chk("end_enable", enc_enable, 0);
        chk("end_din", enc_din, 0);
        chk("end_underrun", underrun, 0);
        chk("handshakes", hs, v.hs);
    endtask

    initial begin
        tv[0] = '{len: 8'd0, offer: 0, b: {8'h00, 8'h00, 8'h00}, hs: 0, und_k: -1, en: 72,  done: 1'b1, hold: 1'b0};
        tv[1] = '{len: 8'd2, offer: 3, b: {8'hFF, 8'h3C, 8'hA5}, hs: 2, und_k: -1, en: 104, done: 1'b1, hold: 1'b0};
        tv[2] = '{len: 8'd3, offer: 2, b: {8'h00, 8'h3C, 8'hA5}, hs: 2, und_k: 96, en: 104, done: 1'b0, hold: 1'b0};
        tv[3] = '{len: 8'd0, offer: 0, b: {8'h00, 8'h00, 8'h00}, hs: 0, und_k: -1, en: 72,  done: 1'b1, hold: 1'b1};
        tv[4] = '{len: 8'd1, offer: 1, b: {8'h00, 8'h00, 8'h5A}, hs: 1, und_k: -1, en: 88,  done: 1'b1, hold: 1'b0};
        tv[5] = '{len: 8'd1, offer: 1, b: {8'h00, 8'h00, 8'hC3}, hs: 1, und_k: -1, en: 88,  done: 1'b1, hold: 1'b0};

        rst_n      = 1'b0;
        start      = 1'b0;
        len        = 8'd0;
        byte_data  = 8'd0;
        byte_valid = 1'b0;
        @(negedge clk2x);
        @(negedge clk2x);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_enable", enc_enable, 0);
        chk("rst_din", enc_din, 0);
        chk("rst_enc_rst_n", enc_rst_n, 0);
        rst_n = 1'b1;
        @(negedge clk2x);
        chk("idle_enc_rst_n", enc_rst_n, 1);
        chk("idle_busy", busy, 0);

        for (int f = 0; f < 3; f++) begin
            start = 1'b1;
            run_frame(tv[f]);
            @(negedge clk2x);
            chk("gap_busy", busy, 0);
        end

        // start held through frame 3 and its done cycle, chaining straight into frame 4
        start = 1'b1;
        run_frame(tv[3]);
        @(negedge clk2x);
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_enable", enc_enable, 0);
        chk("b2b_gap_enc_rst_n", enc_rst_n, 1);
        run_frame(tv[4]);
        @(negedge clk2x);

        // reset pulse mid-payload
        start      = 1'b1;
        len        = 8'd2;
        byte_valid = 1'b1;
        byte_data  = 8'h11;
        @(posedge clk2x);
        @(negedge clk2x);
        start = 1'b0;
        for (int k = 0; k < 71; k++) @(negedge clk2x);
        chk("mid_enable", enc_enable, 1);
        rst_n = 1'b0;
        @(negedge clk2x);
        rst_n      = 1'b1;
        byte_valid = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_underrun", underrun, 0);
        chk("mrst_byte_ready", byte_ready, 0);
        chk("mrst_enable", enc_enable, 0);
        chk("mrst_din", enc_din, 0);
        chk("mrst_enc_rst_n", enc_rst_n, 0);
        @(negedge clk2x);
        chk("post_rst_enc_rst_n", enc_rst_n, 1);
        chk("post_rst_busy", busy, 0);
        start = 1'b1;
        run_frame(tv[5]);
        @(negedge clk2x);
        chk("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
